// File: rtl/lf_pipelined_subtractor.sv
// lf_pipelined_subtractor
//   Pipelined Ladner-Fischer prefix subtractor on a valid/ready stream.
//   Computes diff = a - b - bin (mod 2^WIDTH) as a + ~b + ~bin through a
//   prefix tree, with PIPE register cuts spread evenly over the tree levels.
//   It also produces the unsigned borrow-out and the signed overflow flag.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   PIPE   register cuts inside the prefix tree, 0..clog2(WIDTH)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  result beat valid
//   out_ready  sink accepts the result this cycle
//   diff       a - b - bin mod 2^WIDTH
//   bout       borrow-out (unsigned a < b + bin)
//   ovf        signed overflow
//
// Pipeline: input reg -> PIPE tree-level regs -> output reg, latency PIPE+1.
// A single global enable advances every stage, so bubbles are kept and order is FIFO.
module lf_pipelined_subtractor #(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned LEVELS = $clog2(WIDTH);

    if ((PIPE > LEVELS) || (WIDTH < 2)) begin : g_bad_params
        $error("lf_pipelined_subtractor: need WIDTH >= 2 and PIPE <= clog2(WIDTH)");
    end

    // First tree level handled by segment s; segment s covers [seg_lo(s), seg_lo(s+1)).
    // The last segment always gets at least one level.
    function automatic int unsigned seg_lo(input int unsigned s);
        return (s * LEVELS) / (PIPE + 1);
    endfunction

    // Stage s register (s = 0 is the input register, s >= 1 the tree cuts).
    // g_q/p_q: group generate/propagate so far; x_q: raw per-bit propagate kept
    // for the final sum; cin_q: inverted borrow-in; sgn_q: sign of a.
    logic             v_q   [PIPE+1];
    logic [WIDTH-1:0] g_q   [PIPE+1];
    logic [WIDTH-1:0] p_q   [PIPE+1];
    logic [WIDTH-1:0] x_q   [PIPE+1];
    logic             cin_q [PIPE+1];
    logic             sgn_q [PIPE+1];

    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    // Combinational result of each tree segment, consumed by the next register.
    logic [WIDTH-1:0] seg_g [PIPE+1];
    logic [WIDTH-1:0] seg_p [PIPE+1];

    logic             en;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d;
    logic             ovf_d;

    assign en = !out_valid_q || out_ready;

    // Sklansky-style LF tree, evaluated in place: at level l, bit i (bit l set)
    // absorbs the group ending at j = (i with low l+1 bits cleared) + 2^l - 1,
    // whose bit l is clear, so j is never updated in the same level.
    always_comb begin : tree_comb
        logic [WIDTH-1:0] gt;
        logic [WIDTH-1:0] pt;
        int unsigned      j;
        gt = '0;
        pt = '0;
        j  = 0;
        for (int unsigned s = 0; s <= PIPE; s++) begin
            gt = g_q[s];
            pt = p_q[s];
            // Fold the carry-in into bit 0 so every group G[i:0] is a true carry-out.
            if (s == 0) begin
                gt[0] = g_q[0][0] | (p_q[0][0] & cin_q[0]);
            end
            for (int unsigned l = 0; l < LEVELS; l++) begin
                if ((l >= seg_lo(s)) && (l < seg_lo(s + 1))) begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (((i >> l) & 32'd1) != 0) begin
                            j     = ((i >> l) << l) - 1;
                            gt[i] = gt[i] | (pt[i] & gt[j]);
                            pt[i] = pt[i] & pt[j];
                        end
                    end
                end
            end
            seg_g[s] = gt;
            seg_p[s] = pt;
        end
    end

    // Sum and flags. carry[i] is the carry into bit i; a carry-out of the
    // a + ~b + ~bin sum means no borrow. a and b differ in sign iff x[W-1] = 0.
    always_comb begin
        carry  = {seg_g[PIPE][WIDTH-2:0], cin_q[PIPE]};
        diff_d = x_q[PIPE] ^ carry;
        bout_d = ~seg_g[PIPE][WIDTH-1];
        ovf_d  = ~x_q[PIPE][WIDTH-1] & (diff_d[WIDTH-1] ^ sgn_q[PIPE]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s <= PIPE; s++) begin
                v_q[s]   <= 1'b0;
                g_q[s]   <= '0;
                p_q[s]   <= '0;
                x_q[s]   <= '0;
                cin_q[s] <= 1'b0;
                sgn_q[s] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            v_q[0] <= in_valid;
            if (in_valid) begin
                // p_q[0] and x_q[0] hold the same value; only x travels unmodified.
                p_q[0]   <= a ^ ~b;
                x_q[0]   <= a ^ ~b;
                g_q[0]   <= a & ~b;
                cin_q[0] <= ~bin;
                sgn_q[0] <= a[WIDTH-1];
            end
            for (int unsigned s = 1; s <= PIPE; s++) begin
                v_q[s] <= v_q[s-1];
                if (v_q[s-1]) begin
                    g_q[s]   <= seg_g[s-1];
                    p_q[s]   <= seg_p[s-1];
                    x_q[s]   <= x_q[s-1];
                    cin_q[s] <= cin_q[s-1];
                    sgn_q[s] <= sgn_q[s-1];
                end
            end
            out_valid_q <= v_q[PIPE];
            if (v_q[PIPE]) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_lf_pipelined_subtractor.sv
// Self-checking bench for lf_pipelined_subtractor (WIDTH=22, PIPE=2).
module tb_lf_pipelined_subtractor;

    localparam int unsigned W = 22;
    localparam int unsigned P = 2;
    localparam logic [W-1:0] MASK = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int sent     = 0;
    int got      = 0;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    res_t exp_q[$];

    lf_pipelined_subtractor #(
        .WIDTH (W),
        .PIPE  (P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain signed arithmetic on the operand values.
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin);
        longint d;
        res_t   r;
        d      = longint'(ma) - longint'(mb) - longint'(mbin);
        r.diff = d[W-1:0];
        r.bout = (d < 0);
        r.ovf  = (ma[W-1] != mb[W-1]) && (r.diff[W-1] != ma[W-1]);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = MASK;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    // One clock with stream monitoring against the expected-result queue.
    task automatic step();
        logic         hs_in, hs_out, stalled;
        logic [W-1:0] cd;
        logic         cb, co;
        res_t         e;
        #1;
        hs_in   = in_valid && in_ready;
        hs_out  = out_valid && out_ready;
        stalled = out_valid && !out_ready;
        cd = diff;
        cb = bout;
        co = ovf;
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        tick();
        if (stalled) begin
            chk("stall_hold", {out_valid, diff, bout, ovf}, {1'b1, cd, cb, co});
        end
        if (hs_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_result", {cd, cb, co}, {e.diff, e.bout, e.ovf});
            end
            got++;
        end
        if (hs_in) begin
            exp_q.push_back(model(a, b, bin));
            sent++;
        end
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        int cyc;
        a         = v.a;
        b         = v.b;
        bin       = v.bin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({name, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({name, " latency"}, cyc, P + 1);
        chk({name, " diff"}, diff, v.diff);
        chk({name, " bout"}, bout, v.bout);
        chk({name, " ovf"}, ovf, v.ovf);
        tick();
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int   cyc;
        int   stall_cnt;
        bit   stall_done;
        int   e_first;
        int   e_last;

        tbl[0] = '{a: 22'h000005, b: 22'h000003, bin: 1'b0, diff: 22'h000002, bout: 1'b0, ovf: 1'b0};
        tbl[1] = '{a: 22'h000000, b: 22'h000001, bin: 1'b0, diff: 22'h3FFFFF, bout: 1'b1, ovf: 1'b0};
        tbl[2] = '{a: 22'h3FFFFF, b: 22'h3FFFFF, bin: 1'b1, diff: 22'h3FFFFF, bout: 1'b1, ovf: 1'b0};
        tbl[3] = '{a: 22'h2AAAAA, b: 22'h2AAAAA, bin: 1'b0, diff: 22'h000000, bout: 1'b0, ovf: 1'b0};
        tbl[4] = '{a: 22'h1FFFFF, b: 22'h200000, bin: 1'b0, diff: 22'h3FFFFF, bout: 1'b1, ovf: 1'b1};
        tbl[5] = '{a: 22'h200000, b: 22'h000001, bin: 1'b0, diff: 22'h1FFFFF, bout: 1'b0, ovf: 1'b1};
        tbl[6] = '{a: 22'h123456, b: 22'h000000, bin: 1'b0, diff: 22'h123456, bout: 1'b0, ovf: 1'b0};
        tbl[7] = '{a: 22'h000000, b: 22'h000000, bin: 1'b1, diff: 22'h3FFFFF, bout: 1'b1, ovf: 1'b0};
        tbl[8] = '{a: 22'h2AAAAA, b: 22'h2AAAAA, bin: 1'b1, diff: 22'h3FFFFF, bout: 1'b1, ovf: 1'b0};
        tbl[9] = '{a: 22'h000000, b: 22'h3FFFFF, bin: 1'b0, diff: 22'h000001, bout: 1'b1, ovf: 1'b0};

        // Reset state
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        tick();
        tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset diff", diff, 0);
        chk("reset bout", bout, 0);
        chk("reset ovf", ovf, 0);
        rst = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 1);

        // Directed vectors, one beat at a time
        for (int i = 0; i < 10; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // 6 back-to-back beats with a 3-cycle out_ready drop
        exp_q.delete();
        sent       = 0;
        got        = 0;
        stall_cnt  = 0;
        stall_done = 1'b0;
        e_first    = -1;
        e_last     = -1;
        cyc        = 0;
        while (got < 6 && cyc < 60) begin
            in_valid = (sent < 6);
            a        = W'(sent * 'h1111 + 'h31);
            b        = W'(sent * 'h0707 + 'h2);
            bin      = sent[0];
            if (got == 1 && !stall_done) begin
                stall_done = 1'b1;
                stall_cnt  = 3;
            end
            out_ready = (stall_cnt == 0);
            if (stall_cnt > 0) stall_cnt--;
            step();
            if (sent >= 1 && e_first < 0) e_first = edge_cnt;
            if (out_valid && got == 5 && e_last < 0) e_last = edge_cnt;
            cyc++;
        end
        chk("burst results", got, 6);
        chk("burst total cycles", e_last - e_first + 1, 12);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 22'h000100;
        b         = 22'h000001;
        bin       = 1'b0;
        tick();
        a = 22'h000200;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("inflight out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset diff", diff, 0);
        tick();
        rst = 1'b0;
        #1;
        v = '{a: 22'h000010, b: 22'h000001, bin: 1'b0, diff: 22'h00000F, bout: 1'b0, ovf: 1'b0};
        apply_vec(v, "post_reset");

        // Random stream against the reference model
        exp_q.delete();
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a         = rand_op();
            b         = rand_op();
            bin       = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        chk("random beats sent", sent, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("random drain", exp_q.size(), 0);
        chk("random beats received", got, sent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
